psum_exchange_nc: RTL and testbench
===================================

// Module: psum_exchange_nc
// PURPOSE
//  N-core partial-sum exchange/reduction unit for the normalisation path: each core pushes its per-row
//  sum_out (bw_psum+4 wide) and the block returns one global row total (or max) for the dividers.
//  Generalises the two-core cross-sum link to NCORE channels, with per-channel buffering, valid/ready
//  flow control, a reduce-mode select and a row tag. Single clock domain; cores feed it after their sync stage.
// PARAMETERS
//  NCORE   2   number of core channels (>=2)
//  BW_SUM  24  width of one channel's partial sum, two's complement (bw_psum+4)
//  DEPTH   8   entries per channel FIFO, power of two, >=2
//  TAG_W   4   width of row tag counter
//  OUT_BW  BW_SUM+$clog2(NCORE)  result width (derived, not overridden)
// PORTS
//  clk        in   1             clock, all state on rising edge
//  reset      in   1             synchronous, active-high
//  in_valid   in   NCORE         channel i offers in_data slice i
//  in_data    in   NCORE*BW_SUM  channel i at [i*BW_SUM +: BW_SUM], signed
//  in_ready   out  NCORE         channel i FIFO can accept
//  mode       in   1             0 = signed sum, 1 = signed max; sampled at fire
//  out_valid  out  1             result register holds a row result
//  out_data   out  OUT_BW        signed reduced row value
//  out_tag    out  TAG_W         row index of out_data
//  out_mode   out  1             mode used for out_data
//  out_ready  in   1             consumer accepts result
//  fifo_empty out  NCORE         per-channel empty flag (debug/stall visibility)
// BEHAVIOUR
//  Reset: all FIFOs flushed, out_valid=0, out_data=0, out_tag=0, out_mode=0, fifo_empty=all 1;
//   in_ready=0 in every cycle reset is high, 1 in the first cycle after reset deasserts.
//  Mid-operation reset: buffered and in-flight rows discarded, tag returns to 0; no partial result emitted.
//  Push: channel i writes on edge where in_valid[i]&&in_ready[i]; in_ready[i]=!full[i] (registered-state,
//   no full-bypass: a full FIFO never accepts, even when popped that cycle).
//  Fire: fire = &(~fifo_empty) && (!out_valid || out_ready). On fire edge: pop head of every FIFO,
//   load out_data/out_mode, out_tag <= row counter, row counter += 1 (wraps 2^TAG_W-1 -> 0), out_valid <= 1.
//  No fire and out_valid && out_ready: out_valid <= 0, out_data holds.
//  Latency: entry written at edge E by the last-arriving channel -> out_valid=1 after edge E+1.
//  Throughput: one row per cycle when all channels stream and out_ready=1.
//  Back-pressure: out_valid && !out_ready holds out_* stable; FIFOs keep filling until full.
//  Simultaneous push and pop on same FIFO (not full) allowed; level unchanged.
//  Arithmetic: operands sign-extended to OUT_BW; sum never overflows by construction.
//   max mode: signed compare, ties pick lowest channel (value identical anyway), result sign-extended.
//  Channel order of arrival is irrelevant; row k of every channel is reduced together (FIFO order).
//  Mode change takes effect on the next fire only; buffered rows are not re-tagged.
// STRUCTURE
//  Package psum_xchg_pkg: MODE_SUM/MODE_MAX constants, OUT_BW derivation function, default params.
//  Sub-module psum_fifo (sync FIFO: DEPTH, width BW_SUM, full/empty, ptr with wrap bit), NCORE instances.
//  Reduction is a combinational loop over channels feeding the output register; no other hierarchy.
// TESTING
//  Reset: hold reset 3 cycles with in_valid=all 1 -> in_ready=0, out_valid=0, no FIFO writes.
//  Sum: NCORE=2, ch0=100, ch1=-30 same edge, mode=0 -> out_data=70, out_tag=0, out_valid 2 edges later.
//  Skew+max: ch0 rows {5,-7,9} early, ch1 rows {3,-2,12} 4 cycles later, mode=1 -> 5,-2,12 tags 0,1,2.
//  Back-pressure: out_ready=0, ch0 pushes 10 rows -> in_ready[0]=0 after 8 accepted; out_* stable;
//   release -> 8 results in order, then remaining rows, no loss/duplication.
//  Extremes/wrap: NCORE=4, all -2^23 -> out_data=-2^25; stream 20 rows TAG_W=4 -> tags 0..15,0..3.
//  Reset mid-run: 3 rows buffered, out_valid=1, assert reset 1 cycle -> out_valid=0, next row tag 0.

Source files
------------

// File: rtl/psum_xchg_pkg.sv
// Shared constants for the partial-sum exchange unit.
//   MODE_SUM / MODE_MAX : encodings of the reduce-mode select
//   DEF_*               : default parameter values
//   calc_out_bw()       : result width, wide enough that an NCORE-way sum cannot overflow
package psum_xchg_pkg;

    localparam logic MODE_SUM = 1'b0;
    localparam logic MODE_MAX = 1'b1;

    localparam int unsigned DEF_NCORE  = 2;
    localparam int unsigned DEF_BW_SUM = 24;
    localparam int unsigned DEF_DEPTH  = 8;
    localparam int unsigned DEF_TAG_W  = 4;

    function automatic int unsigned calc_out_bw(input int unsigned bw_sum, input int unsigned ncore);
        return bw_sum + $clog2(ncore);
    endfunction

endpackage

// File: rtl/psum_fifo.sv
// Per-channel synchronous FIFO for partial sums.
//   clk, reset  : clock, synchronous active-high reset (flushes contents)
//   push, pop   : write / read requests (ignored when full / empty)
//   wr_data     : entry written on push
//   rd_data_c   : current head entry (combinational read of the head slot)
//   full, empty : registered status flags
module psum_fifo
    import psum_xchg_pkg::*;
#(
    parameter int unsigned DEPTH = DEF_DEPTH,
    parameter int unsigned WIDTH = DEF_BW_SUM
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data_c,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    // Pointers carry an extra wrap bit to tell full from empty.
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [AW:0]      wr_ptr_nxt;
    logic [AW:0]      rd_ptr_nxt;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Next pointer values.
    always_comb begin
        wr_ptr_nxt = wr_ptr + (AW+1)'(do_push);
        rd_ptr_nxt = rd_ptr + (AW+1)'(do_pop);
    end

    // Pointers and flags, flags computed from next pointers so they are registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
        end else begin
            wr_ptr <= wr_ptr_nxt;
            rd_ptr <= rd_ptr_nxt;
            empty  <= (wr_ptr_nxt == rd_ptr_nxt);
            full   <= (wr_ptr_nxt[AW] != rd_ptr_nxt[AW]) &&
                      (wr_ptr_nxt[AW-1:0] == rd_ptr_nxt[AW-1:0]);
        end
    end

    // Storage array, no reset needed.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

    assign rd_data_c = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/psum_exchange_nc.sv
// N-core partial-sum exchange/reduction: buffers one row of partial sums per core channel
// and emits the signed sum (or max) of row k across all channels with a row tag.
//   clk, reset         : clock, synchronous active-high reset
//   in_valid/in_ready  : per-channel push handshake, in_data slice i = [i*BW_SUM +: BW_SUM]
//   mode               : 0 = sum, 1 = max, sampled when a row fires
//   out_valid/out_ready: result handshake; out_data/out_tag/out_mode describe the result
//   fifo_empty         : per-channel empty flags
module psum_exchange_nc
    import psum_xchg_pkg::*;
#(
    parameter int unsigned NCORE  = DEF_NCORE,
    parameter int unsigned BW_SUM = DEF_BW_SUM,
    parameter int unsigned DEPTH  = DEF_DEPTH,
    parameter int unsigned TAG_W  = DEF_TAG_W,
    localparam int unsigned OUT_BW = calc_out_bw(BW_SUM, NCORE)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NCORE-1:0]        in_valid,
    input  logic [NCORE*BW_SUM-1:0] in_data,
    output logic [NCORE-1:0]        in_ready,
    input  logic                    mode,
    output logic                    out_valid,
    output logic [OUT_BW-1:0]       out_data,
    output logic [TAG_W-1:0]        out_tag,
    output logic                    out_mode,
    input  logic                    out_ready,
    output logic [NCORE-1:0]        fifo_empty
);

    logic [NCORE-1:0]        full;
    logic [NCORE-1:0]        push;
    logic [NCORE*BW_SUM-1:0] head_flat;
    logic                    fire;
    logic [TAG_W-1:0]        row_cnt;
    logic signed [OUT_BW-1:0] opnd_c;
    logic signed [OUT_BW-1:0] sum_c;
    logic signed [OUT_BW-1:0] max_c;
    logic signed [OUT_BW-1:0] red_c;

    // Ready straight from the full flag; held low while reset is asserted.
    assign in_ready = ~full & {NCORE{~reset}};
    assign push     = in_valid & in_ready;

    // A row fires once every channel holds an entry and the result slot is free or draining.
    assign fire = (&(~fifo_empty)) && (!out_valid || out_ready);

    for (genvar g = 0; g < NCORE; g++) begin : g_ch
        psum_fifo #(
            .DEPTH (DEPTH),
            .WIDTH (BW_SUM)
        ) u_fifo (
            .clk       (clk),
            .reset     (reset),
            .push      (push[g]),
            .pop       (fire),
            .wr_data   (in_data[g*BW_SUM +: BW_SUM]),
            .rd_data_c (head_flat[g*BW_SUM +: BW_SUM]),
            .full      (full[g]),
            .empty     (fifo_empty[g])
        );
    end

    // Reduce the head row; strict '>' keeps the lowest channel on ties.
    always_comb begin
        opnd_c = '0;
        sum_c  = '0;
        max_c  = OUT_BW'(signed'(head_flat[0 +: BW_SUM]));
        for (int unsigned i = 0; i < NCORE; i++) begin
            opnd_c = OUT_BW'(signed'(head_flat[i*BW_SUM +: BW_SUM]));
            sum_c  = sum_c + opnd_c;
            if (opnd_c > max_c) begin
                max_c = opnd_c;
            end
        end
        red_c = (mode == MODE_MAX) ? max_c : sum_c;
    end

    // Result register and row counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_tag   <= '0;
            out_mode  <= MODE_SUM;
            row_cnt   <= '0;
        end else if (fire) begin
            out_valid <= 1'b1;
            out_data  <= red_c;
            out_mode  <= mode;
            out_tag   <= row_cnt;
            row_cnt   <= row_cnt + TAG_W'(1);
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_psum_exchange_nc.sv
// Bench for psum_exchange_nc: queue-based reference model plus per-cycle comparison,
// directed scenarios pinned with literal expectations, then a randomized run.
module tb_psum_exchange_nc;

    localparam int NC = 4;
    localparam int BW = 24;
    localparam int DP = 8;
    localparam int TW = 4;
    localparam int OW = 26;

    logic              clk = 1'b0;
    logic              reset;
    logic [NC-1:0]     in_valid;
    logic [NC*BW-1:0]  in_data;
    logic [NC-1:0]     in_ready;
    logic              mode;
    logic              out_valid;
    logic [OW-1:0]     out_data;
    logic [TW-1:0]     out_tag;
    logic              out_mode;
    logic              out_ready;
    logic [NC-1:0]     fifo_empty;

    psum_exchange_nc #(
        .NCORE  (NC),
        .BW_SUM (BW),
        .DEPTH  (DP),
        .TAG_W  (TW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .mode       (mode),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_tag    (out_tag),
        .out_mode   (out_mode),
        .out_ready  (out_ready),
        .fifo_empty (fifo_empty)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        longint data;
        int     tag;
        int     md;
    } res_t;
    res_t dut_log[$];

    // Reference model: one queue of pending rows per channel plus the result slot.
    int     mq[NC][$];
    bit     m_valid = 1'b0;
    longint m_data  = 0;
    int     m_tag   = 0;
    int     m_mode  = 0;
    int     m_row   = 0;
    bit     m_fire;
    longint m_sum;
    longint m_max;
    int     m_v;
    int     m_sz[NC];

    function automatic int sx(input logic [BW-1:0] x);
        return int'(signed'(x));
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NC; i++) mq[i].delete();
            m_valid = 1'b0;
            m_data  = 0;
            m_tag   = 0;
            m_mode  = 0;
            m_row   = 0;
        end else begin
            m_fire = 1'b1;
            for (int i = 0; i < NC; i++) begin
                m_sz[i] = mq[i].size();
                if (m_sz[i] == 0) m_fire = 1'b0;
            end
            if (m_valid && !out_ready) m_fire = 1'b0;
            if (m_fire) begin
                m_sum = 0;
                m_max = 0;
                for (int i = 0; i < NC; i++) begin
                    m_v = mq[i].pop_front();
                    m_sum += m_v;
                    if (i == 0 || m_v > m_max) m_max = m_v;
                end
                m_data  = mode ? m_max : m_sum;
                m_mode  = int'(mode);
                m_tag   = m_row;
                m_row   = (m_row + 1) % (1 << TW);
                m_valid = 1'b1;
            end else if (out_ready) begin
                m_valid = 1'b0;
            end
            for (int i = 0; i < NC; i++) begin
                if (in_valid[i] && m_sz[i] < DP) mq[i].push_back(sx(in_data[i*BW +: BW]));
            end
        end
    end

    task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // One cycle: compare everything against the model at the falling edge, then advance.
    task automatic tick();
        logic [NC-1:0] er;
        logic [NC-1:0] ee;
        res_t r;
        @(negedge clk);
        for (int i = 0; i < NC; i++) begin
            er[i] = !reset && (mq[i].size() < DP);
            ee[i] = (mq[i].size() == 0);
        end
        chk("out_valid", out_valid, m_valid);
        chk("out_data", 64'(signed'(out_data)), m_data);
        chk("out_tag", out_tag, m_tag);
        chk("out_mode", out_mode, m_mode);
        chk("in_ready", in_ready, er);
        chk("fifo_empty", fifo_empty, ee);
        if (!reset && out_valid && out_ready) begin
            r.data = 64'(signed'(out_data));
            r.tag  = int'(out_tag);
            r.md   = int'(out_mode);
            dut_log.push_back(r);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_all(input int v);
        for (int i = 0; i < NC; i++) in_data[i*BW +: BW] = BW'(v);
    endtask

    task automatic do_reset(input int n);
        reset    = 1'b1;
        in_valid = '0;
        repeat (n) tick();
        reset = 1'b0;
        dut_log.delete();
    endtask

    task automatic chk_log(input string nm, input int idx, input longint d, input int t, input int md);
        if (idx >= dut_log.size()) begin
            chk({nm, "_missing"}, dut_log.size(), idx + 1);
        end else begin
            chk({nm, "_data"}, dut_log[idx].data, d);
            chk({nm, "_tag"}, dut_log[idx].tag, t);
            chk({nm, "_mode"}, dut_log[idx].md, md);
        end
    endtask

    int rows0[3] = '{5, -7, 9};
    int rows1[3] = '{3, -2, 12};
    int maxes[3] = '{5, -2, 12};

    initial begin
        reset     = 1'b1;
        in_valid  = '1;
        in_data   = '0;
        mode      = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < NC; i++) in_data[i*BW +: BW] = BW'($urandom());

        // Reset held with all channels offering data.
        repeat (3) tick();
        chk("rst_ready_low", in_ready, 0);
        chk("rst_empty", fifo_empty, 4'hF);
        chk("rst_out_valid", out_valid, 0);
        reset    = 1'b0;
        in_valid = '0;
        #1;
        chk("ready_after_rst", in_ready, 4'hF);
        tick();

        // Signed sum and two-edge latency.
        do_reset(1);
        mode     = 1'b0;
        in_valid = '1;
        set_all(0);
        in_data[0*BW +: BW] = BW'(100);
        in_data[1*BW +: BW] = BW'(-30);
        tick();
        in_valid = '0;
        chk("sum_lat_early", out_valid, 0);
        tick();
        chk("sum_valid", out_valid, 1);
        chk("sum_data", 64'(signed'(out_data)), 70);
        chk("sum_tag", out_tag, 0);
        repeat (3) tick();

        // Skewed arrival, max mode.
        do_reset(1);
        mode = 1'b1;
        for (int r = 0; r < 3; r++) begin
            in_valid = 4'b0101;
            in_data[0*BW +: BW] = BW'(rows0[r]);
            in_data[2*BW +: BW] = BW'(rows0[r]);
            tick();
        end
        in_valid = '0;
        repeat (4) tick();
        for (int r = 0; r < 3; r++) begin
            in_valid = 4'b1010;
            in_data[1*BW +: BW] = BW'(rows1[r]);
            in_data[3*BW +: BW] = BW'(rows1[r]);
            tick();
        end
        in_valid = '0;
        repeat (5) tick();
        chk("max_count", dut_log.size(), 3);
        for (int r = 0; r < 3; r++) chk_log("max_row", r, maxes[r], r, 1);

        // Back-pressure: fill every FIFO while the result is stalled.
        do_reset(1);
        mode      = 1'b0;
        out_ready = 1'b0;
        for (int r = 0; r < 12; r++) begin
            in_valid = '1;
            for (int i = 0; i < NC; i++) in_data[i*BW +: BW] = BW'(r * 10 + i);
            tick();
        end
        in_valid = '0;
        chk("bp_ready_low", in_ready, 0);
        chk("bp_hold_valid", out_valid, 1);
        chk("bp_hold_data", 64'(signed'(out_data)), 6);
        repeat (3) tick();
        out_ready = 1'b1;
        repeat (12) tick();
        chk("bp_drain_count", dut_log.size(), 9);
        for (int r = 9; r < 12; r++) begin
            in_valid = '1;
            for (int i = 0; i < NC; i++) in_data[i*BW +: BW] = BW'(r * 10 + i);
            tick();
        end
        in_valid = '0;
        repeat (5) tick();
        chk("bp_total_count", dut_log.size(), 12);
        for (int r = 0; r < 12; r++) chk_log("bp_row", r, 40 * r + 6, r, 0);

        // Most-negative operands in both modes.
        do_reset(1);
        mode     = 1'b0;
        in_valid = '1;
        set_all(-8388608);
        tick();
        in_valid = '0;
        tick();
        mode     = 1'b1;
        in_valid = '1;
        tick();
        in_valid = '0;
        repeat (4) tick();
        chk_log("ext_sum", 0, -33554432, 0, 0);
        chk_log("ext_max", 1, -8388608, 1, 1);

        // Tag wrap over a 20-row stream.
        do_reset(1);
        mode = 1'b0;
        for (int r = 0; r < 20; r++) begin
            in_valid = '1;
            set_all(r);
            tick();
        end
        in_valid = '0;
        repeat (5) tick();
        chk("wrap_count", dut_log.size(), 20);
        for (int r = 0; r < 20; r++) chk_log("wrap_row", r, 4 * r, r % 16, 0);

        // Reset in the middle of a stalled run.
        do_reset(1);
        out_ready = 1'b0;
        for (int r = 0; r < 4; r++) begin
            in_valid = '1;
            set_all(r + 1);
            tick();
        end
        in_valid = '0;
        chk("mid_valid_before", out_valid, 1);
        chk("mid_empty_before", fifo_empty, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_valid_after", out_valid, 0);
        chk("mid_empty_after", fifo_empty, 4'hF);
        out_ready = 1'b1;
        in_valid  = '1;
        set_all(7);
        tick();
        in_valid = '0;
        repeat (4) tick();
        chk("mid_count", dut_log.size(), 1);
        chk_log("mid_row", 0, 28, 0, 0);

        // Randomized traffic with occasional resets and extreme values.
        do_reset(1);
        for (int c = 0; c < 3000; c++) begin
            reset    = ($urandom_range(0, 299) == 0);
            in_valid = ($urandom_range(0, 2) == 0) ? NC'($urandom()) : '1;
            for (int i = 0; i < NC; i++) begin
                case ($urandom_range(0, 9))
                    0:       in_data[i*BW +: BW] = BW'(-8388608);
                    1:       in_data[i*BW +: BW] = BW'(8388607);
                    default: in_data[i*BW +: BW] = BW'($urandom());
                endcase
            end
            if ($urandom_range(0, 9) == 0) mode = ~mode;
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        reset    = 1'b0;
        in_valid = '0;
        repeat (3) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
